// File: rtl/lfm_dds_pkg.sv
// ---------------------------------------------------------------------------
// lfm_dds_pkg
// Shared definitions for the LFM / CW direct digital synthesiser:
//   - burst mode encodings (MODE_CW, MODE_CHIRP)
//   - control FSM state encoding (IDLE, RUN, FLUSH)
//   - quarter-wave ROM depth and ROM contents functions
// Optional feature macro used elsewhere in this slice: LFM_DDS_COS_OUT_EN
// (adds the quadrature output and a second ROM read port).
// ---------------------------------------------------------------------------
package lfm_dds_pkg;

  localparam logic MODE_CW    = 1'b0;
  localparam logic MODE_CHIRP = 1'b1;

  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Number of entries in the quarter-wave ROM.
  function automatic int lut_depth(input int lut_aw);
    return 1 << lut_aw;
  endfunction

  // Magnitude stored at ROM index idx. The half-index offset centres each
  // entry inside its phase bin, so folding about pi/2 maps entry i onto
  // entry N-1-i exactly and the negated output never reaches the most
  // negative code.
  function automatic int lut_value(input int idx, input int lut_aw, input int out_w);
    real amp;
    real arg;
    amp = (2.0 ** (out_w - 1)) - 1.0;
    arg = 2.0 * PI * (real'(idx) + 0.5) / (4.0 * real'(lut_depth(lut_aw)));
    return $rtoi(amp * $sin(arg) + 0.5);
  endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// ---------------------------------------------------------------------------
// dds_sine_lut
// Synchronous quarter-wave sine ROM, one clock of read latency. Entries are
// unsigned magnitudes of OUT_W-1 bits; sign is applied by the caller.
// Ports:
//   clk_i     in   clock (rising edge)
//   addr_a_i  in   LUT_AW  read address, port A (sine path)
//   data_a_o  out  OUT_W-1 registered ROM data, port A
//   addr_b_i  in   LUT_AW  read address, port B (only with LFM_DDS_COS_OUT_EN)
//   data_b_o  out  OUT_W-1 registered ROM data, port B (only with LFM_DDS_COS_OUT_EN)
// Macro: LFM_DDS_COS_OUT_EN makes the ROM dual-read for the cosine path.
// ---------------------------------------------------------------------------
module dds_sine_lut
  import lfm_dds_pkg::*;
#(
  parameter int LUT_AW = 10,
  parameter int OUT_W  = 16
) (
  input  logic              clk_i,
  input  logic [LUT_AW-1:0] addr_a_i,
  output logic [OUT_W-2:0]  data_a_o
`ifdef LFM_DDS_COS_OUT_EN
  ,
  input  logic [LUT_AW-1:0] addr_b_i,
  output logic [OUT_W-2:0]  data_b_o
`endif
);

  localparam int DEPTH = lut_depth(LUT_AW);

  logic [OUT_W-2:0] rom [DEPTH];

  // Constant contents; each entry is a fixed value so the array maps to ROM.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom[gi] = (OUT_W-1)'(lut_value(gi, LUT_AW, OUT_W));
  end

  always_ff @(posedge clk_i) begin
    data_a_o <= rom[addr_a_i];
  end

`ifdef LFM_DDS_COS_OUT_EN
  always_ff @(posedge clk_i) begin
    data_b_o <= rom[addr_b_i];
  end
`endif

endmodule

// File: rtl/lfm_dds_gen.sv
// ---------------------------------------------------------------------------
// lfm_dds_gen
// Burst DDS for the radar chain: CW or linear-FM chirp from a phase
// accumulator plus a quarter-wave sine ROM, with start/busy/done handshake.
// Ports:
//   sys_clock   in   clock, rising edge
//   sys_reset   in   synchronous active-high reset
//   start       in   burst request, sampled only when idle
//   cfg_mode    in   0 = CW, 1 = chirp (latched on accepted start)
//   cfg_fstart  in   PHASE_W start tuning word (unsigned)
//   cfg_fstep   in   PHASE_W signed tuning-word increment per sample
//   cfg_len     in   LEN_W   samples per burst
//   busy        out  burst in progress
//   done        out  one-cycle pulse when the burst has fully drained
//   out_valid   out  sample valid
//   out_sin     out  OUT_W signed sine sample (held while not valid)
//   out_cos     out  OUT_W signed cosine sample (only with LFM_DDS_COS_OUT_EN)
//   out_last    out  final sample of the burst
// Macro: LFM_DDS_COS_OUT_EN enables the quadrature output.
// Pipeline: phase fold register -> ROM read -> sign register, so the first
// sample appears three clocks after start is accepted.
// ---------------------------------------------------------------------------
module lfm_dds_gen
  import lfm_dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  parameter int OUT_W   = 16,
  parameter int LEN_W   = 16
) (
  input  logic                    sys_clock,
  input  logic                    sys_reset,
  input  logic                    start,
  input  logic                    cfg_mode,
  input  logic [PHASE_W-1:0]      cfg_fstart,
  input  logic [PHASE_W-1:0]      cfg_fstep,
  input  logic [LEN_W-1:0]        cfg_len,
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_sin,
`ifdef LFM_DDS_COS_OUT_EN
  output logic signed [OUT_W-1:0] out_cos,
`endif
  output logic                    out_last
);

  // Control / accumulator state
  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [PHASE_W-1:0]   fstep_q, fstep_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [PHASE_W-1:0]   freq_q, freq_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;

  logic                 issue;
  logic                 issue_last;

  // Phase fold (combinational from the accumulator)
  logic [1:0]           quad;
  logic [LUT_AW-1:0]    idx;
  logic [LUT_AW-1:0]    addr_s;

  // Stage 1: folded address and sign
  logic                 s1_vld_q, s1_last_q, s1_neg_s_q;
  logic [LUT_AW-1:0]    s1_addr_s_q;

  // Stage 2: ROM data and delayed sign
  logic                 s2_vld_q, s2_last_q, s2_neg_s_q;
  logic [OUT_W-2:0]     rom_sin;

  // Stage 3: output registers
  logic                 out_vld_q, out_last_q;
  logic [OUT_W-1:0]     sin_ext, sin_fold, sin_q;

`ifdef LFM_DDS_COS_OUT_EN
  logic [1:0]           quad_c;
  logic [LUT_AW-1:0]    addr_c;
  logic                 s1_neg_c_q, s2_neg_c_q;
  logic [LUT_AW-1:0]    s1_addr_c_q;
  logic [OUT_W-2:0]     rom_cos;
  logic [OUT_W-1:0]     cos_ext, cos_fold, cos_q;
`endif

  // A phase is issued on every RUN cycle while samples remain.
  assign issue      = (state_q == RUN) && (cnt_q != '0);
  assign issue_last = issue && (cnt_q == LEN_W'(1));

  // -------------------------------------------------------------------------
  // Control FSM and accumulators
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    fstep_d = fstep_q;
    phase_d = phase_q;
    freq_d  = freq_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = cfg_mode;
          fstep_d = cfg_fstep;
          phase_d = '0;
          freq_d  = cfg_fstart;
          cnt_d   = cfg_len;
        end
      end

      RUN: begin
        if (cnt_q == '0) begin
          // Only reachable for a zero-length burst: nothing enters the
          // pipeline, so finish immediately.
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q + freq_q;
          case (mode_q)
            MODE_CW:    freq_d = freq_q;
            MODE_CHIRP: freq_d = freq_q + fstep_q;
            default:    freq_d = freq_q;
          endcase
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = FLUSH;
          end
        end
      end

      FLUSH: begin
        // The last sample was presented in the previous cycle.
        if (out_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Phase fold: quadrant selects mirrored address and output sign.
  // -------------------------------------------------------------------------
  assign quad   = phase_q[PHASE_W-1 -: 2];
  assign idx    = phase_q[PHASE_W-3 -: LUT_AW];
  assign addr_s = quad[0] ? ~idx : idx;

`ifdef LFM_DDS_COS_OUT_EN
  // Cosine is the sine one quadrant ahead, from the same table.
  assign quad_c = quad + 2'd1;
  assign addr_c = quad_c[0] ? ~idx : idx;
`endif

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_CW;
      fstep_q     <= '0;
      phase_q     <= '0;
      freq_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_neg_s_q  <= 1'b0;
      s1_addr_s_q <= '0;
      s2_vld_q    <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_neg_s_q  <= 1'b0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      sin_q       <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fstep_q <= fstep_d;
      phase_q <= phase_d;
      freq_q  <= freq_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;

      s1_vld_q  <= issue;
      s1_last_q <= issue_last;
      if (issue) begin
        s1_addr_s_q <= addr_s;
        s1_neg_s_q  <= quad[1];
      end

      s2_vld_q   <= s1_vld_q;
      s2_last_q  <= s1_last_q;
      s2_neg_s_q <= s1_neg_s_q;

      out_vld_q  <= s2_vld_q;
      out_last_q <= s2_last_q;
      // Output holds its previous value between bursts.
      if (s2_vld_q) begin
        sin_q <= sin_fold;
      end
    end
  end

`ifdef LFM_DDS_COS_OUT_EN
  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      s1_neg_c_q  <= 1'b0;
      s1_addr_c_q <= '0;
      s2_neg_c_q  <= 1'b0;
      cos_q       <= '0;
    end else begin
      if (issue) begin
        s1_addr_c_q <= addr_c;
        s1_neg_c_q  <= quad_c[1];
      end
      s2_neg_c_q <= s1_neg_c_q;
      if (s2_vld_q) begin
        cos_q <= cos_fold;
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // ROM
  // -------------------------------------------------------------------------
  dds_sine_lut #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_lut (
    .clk_i    (sys_clock),
    .addr_a_i (s1_addr_s_q),
    .data_a_o (rom_sin)
`ifdef LFM_DDS_COS_OUT_EN
    ,
    .addr_b_i (s1_addr_c_q),
    .data_b_o (rom_cos)
`endif
  );

  // Sign application: magnitudes are below 2^(OUT_W-1), so negation never
  // overflows.
  assign sin_ext  = {1'b0, rom_sin};
  assign sin_fold = s2_neg_s_q ? -sin_ext : sin_ext;

`ifdef LFM_DDS_COS_OUT_EN
  assign cos_ext  = {1'b0, rom_cos};
  assign cos_fold = s2_neg_c_q ? -cos_ext : cos_ext;
  assign out_cos  = cos_q;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = out_vld_q;
  assign out_last  = out_last_q;
  assign out_sin   = sin_q;

endmodule

// File: tb/tb_lfm_dds_gen.sv
// ---------------------------------------------------------------------------
// tb_lfm_dds_gen
// Directed bench for lfm_dds_gen with default parameters
// (PHASE_W=32, LUT_AW=10, OUT_W=16, LEN_W=16). The reference sine is computed
// on the full 4N-entry circle directly from the truncated phase, independent
// of the quarter-wave fold; fs/4 bursts are also checked against hand values.
// ---------------------------------------------------------------------------
module tb_lfm_dds_gen;

  localparam real PI_TB = 3.14159265358979323846;

  logic               sys_clock = 1'b0;
  logic               sys_reset = 1'b1;
  logic               start     = 1'b0;
  logic               cfg_mode  = 1'b0;
  logic [31:0]        cfg_fstart = '0;
  logic [31:0]        cfg_fstep  = '0;
  logic [15:0]        cfg_len    = '0;
  logic               busy;
  logic               done;
  logic               out_valid;
  logic signed [15:0] out_sin;
  logic               out_last;
`ifdef LFM_DDS_COS_OUT_EN
  logic signed [15:0] out_cos;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clock = ~sys_clock;

  lfm_dds_gen dut (
    .sys_clock  (sys_clock),
    .sys_reset  (sys_reset),
    .start      (start),
    .cfg_mode   (cfg_mode),
    .cfg_fstart (cfg_fstart),
    .cfg_fstep  (cfg_fstep),
    .cfg_len    (cfg_len),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_sin    (out_sin),
`ifdef LFM_DDS_COS_OUT_EN
    .out_cos    (out_cos),
`endif
    .out_last   (out_last)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  // Full-circle reference: index = top 12 phase bits, centred in its bin,
  // rounded half away from zero.
  function automatic int sine_model(input logic [31:0] ph);
    int  j;
    real s;
    j = int'(ph[31:20]);
    s = 32767.0 * $sin(2.0 * PI_TB * (real'(j) + 0.5) / 4096.0);
    if (s >= 0.0) return $rtoi(s + 0.5);
    else          return -$rtoi(0.5 - s);
  endfunction

  // Start one burst and check every cycle until a few cycles after done.
  // hand: also compare against the fs/4 hand table.
  // mid:  pulse start with a different config while the burst is running.
  task automatic run_burst(input string tag, input logic mode, input logic [31:0] fs,
                           input logic [31:0] st, input int len, input bit hand,
                           input bit mid);
    logic [31:0] ph;
    logic [31:0] fr;
    int k;
    int done_c;
    int exp_s;
    int last_s;
    int hand_sin[4];
    int hand_cos[4];
    hand_sin = '{25, 32767, -25, -32767};
    hand_cos = '{32767, -25, -32767, 25};
    last_s = 0;

    cfg_mode   = mode;
    cfg_fstart = fs;
    cfg_fstep  = st;
    cfg_len    = 16'(len);
    start      = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("%s.busy_start", tag), int'(busy), 1);

    ph = '0;
    fr = fs;
    k  = 0;
    done_c = (len == 0) ? 1 : len + 3;

    for (int c = 1; c <= len + 6; c++) begin
      if (mid && c == 2) begin
        start      = 1'b1;
        cfg_mode   = ~mode;
        cfg_fstart = 32'h2000_0000;
        cfg_fstep  = 32'h0100_0000;
        cfg_len    = 16'd3;
      end
      tick();
      start = 1'b0;
      if (c >= 3 && c <= len + 2) begin
        exp_s = sine_model(ph);
        check($sformatf("%s.valid[%0d]", tag, k), int'(out_valid), 1);
        check($sformatf("%s.sin[%0d]", tag, k), int'(out_sin), exp_s);
        check($sformatf("%s.last[%0d]", tag, k), int'(out_last), (k == len - 1) ? 1 : 0);
        if (hand) check($sformatf("%s.hand_sin[%0d]", tag, k), int'(out_sin), hand_sin[k % 4]);
`ifdef LFM_DDS_COS_OUT_EN
        check($sformatf("%s.cos[%0d]", tag, k), int'(out_cos), sine_model(ph + 32'h4000_0000));
        if (hand) check($sformatf("%s.hand_cos[%0d]", tag, k), int'(out_cos), hand_cos[k % 4]);
`endif
        $display("%s sample %0d phase=%08h sin=%0d exp=%0d", tag, k, ph, out_sin, exp_s);
        last_s = exp_s;
        ph = ph + fr;
        if (mode) fr = fr + st;
        k++;
      end else begin
        check($sformatf("%s.novalid_c%0d", tag, c), int'(out_valid), 0);
        check($sformatf("%s.nolast_c%0d", tag, c), int'(out_last), 0);
        if (k > 0) check($sformatf("%s.hold_c%0d", tag, c), int'(out_sin), last_s);
      end
      check($sformatf("%s.done_c%0d", tag, c), int'(done), (c == done_c) ? 1 : 0);
      check($sformatf("%s.busy_c%0d", tag, c), int'(busy), (c < done_c) ? 1 : 0);
    end
    check($sformatf("%s.count", tag), k, len);
  endtask

  initial begin
    // Reset state
    sys_reset = 1'b1;
    repeat (3) tick();
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.valid", int'(out_valid), 0);
    check("rst.sin", int'(out_sin), 0);
    check("rst.last", int'(out_last), 0);
    sys_reset = 1'b0;
    tick();

    run_burst("cw_fs4", 1'b0, 32'h4000_0000, 32'h0, 8, 1'b1, 1'b0);
    run_burst("chirp", 1'b1, 32'h0, 32'h0400_0000, 64, 1'b0, 1'b0);
    run_burst("negwrap", 1'b1, 32'h4000_0000, 32'hFC00_0000, 100, 1'b0, 1'b0);
    run_burst("len0", 1'b0, 32'h4000_0000, 32'h0, 0, 1'b0, 1'b0);
    run_burst("midstart", 1'b1, 32'h0800_0000, 32'h0010_0000, 12, 1'b0, 1'b1);

    // Reset while the 5th of 20 samples is on the output
    cfg_mode   = 1'b0;
    cfg_fstart = 32'h4000_0000;
    cfg_fstep  = 32'h0;
    cfg_len    = 16'd20;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("abort.pre_valid", int'(out_valid), 1);
    check("abort.pre_sin", int'(out_sin), 25);
    sys_reset = 1'b1;
    tick();
    check("abort.busy", int'(busy), 0);
    check("abort.done", int'(done), 0);
    check("abort.valid", int'(out_valid), 0);
    check("abort.sin", int'(out_sin), 0);
    check("abort.last", int'(out_last), 0);
    $display("abort: reset applied at sample 5");
    sys_reset = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      check($sformatf("abort.quiet_valid_c%0d", c), int'(out_valid), 0);
      check($sformatf("abort.quiet_done_c%0d", c), int'(done), 0);
    end
    run_burst("post_abort", 1'b0, 32'h4000_0000, 32'h0, 20, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
